// File: rtl/scan_doubler_n.sv
// scan_doubler_n: N-line ring-buffer scan doubler.
// Source lines are written at the slow pixel enable rate. Each completed line is
// replayed twice at full clk24 rate, optionally dimming the repeat pass.
module scan_doubler_n #(
   parameter int PIXEL_W  = 8,
   parameter int CH_W     = 0,
   parameter int LINE_LEN = 512,
   parameter int ADDR_W   = 9,
   parameter int NLINES   = 2
) (
   input  logic               clk24,
   input  logic               reset,
   input  logic               ce_wr,
   input  logic [PIXEL_W-1:0] wr_pixel,
   input  logic               wr_start,
   input  logic               rd_start,
   input  logic               rd_active,
   input  logic               scanline_en,
   output logic [PIXEL_W-1:0] out_pixel,
   output logic               rd_repeat,
   output logic               wr_ovf,
   output logic               collide
);

   localparam int                BANK_W    = $clog2(NLINES);
   localparam int                DEPTH     = NLINES << ADDR_W;
   localparam int                CH_SAFE   = (CH_W > 0) ? CH_W : PIXEL_W;
   localparam logic [ADDR_W:0]   LEN       = (ADDR_W + 1)'(LINE_LEN);
   localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NLINES - 1);

   // Clears the top bit of every channel so a right shift halves each channel on its own.
   function automatic logic [PIXEL_W-1:0] make_dim_mask();
      logic [PIXEL_W-1:0] m;
      for (int i = 0; i < PIXEL_W; i++) begin
         m[i] = !((i % CH_SAFE) == (CH_SAFE - 1) || i == (PIXEL_W - 1));
      end
      return m;
   endfunction

   localparam logic [PIXEL_W-1:0] DIM_MASK = make_dim_mask();

   logic [PIXEL_W-1:0] mem [0:DEPTH-1];
   logic [PIXEL_W-1:0] ram_q;
   logic [BANK_W-1:0]  wb;
   logic [BANK_W-1:0]  last_done;
   logic [BANK_W-1:0]  rb;
   logic [BANK_W-1:0]  wb_next;
   logic [BANK_W-1:0]  rb_next;
   logic [ADDR_W:0]    wr_addr;
   logic [ADDR_W:0]    rd_addr;
   logic               act_d1;
   logic               dim_d1;
   logic               wr_take;

   // Next write/read bank; a first-pass read started alongside wr_start bypasses in the line just finished.
   always_comb begin
      wb_next = wr_start ? wb + 1'b1 : wb;
      rb_next = rb;
      if (rd_start && rd_repeat) begin
         rb_next = wr_start ? wb : last_done;
      end
      wr_take = ce_wr && !wr_start && (wr_addr < LEN);
   end

   // Write-side line bookkeeping: bank rotation, saturating address, sticky overflow.
   always_ff @(posedge clk24) begin
      if (reset) begin
         wb        <= '0;
         last_done <= LAST_BANK;
         wr_addr   <= '0;
         wr_ovf    <= 1'b0;
      end else if (wr_start) begin
         last_done <= wb;
         wb        <= wb_next;
         wr_addr   <= '0;
         wr_ovf    <= 1'b0;
      end else if (ce_wr) begin
         if (wr_addr < LEN) begin
            wr_addr <= wr_addr + 1'b1;
         end else begin
            wr_ovf <= 1'b1;
         end
      end
   end

   // Line storage write port.
   always_ff @(posedge clk24) begin
      if (!reset && wr_take) begin
         mem[{wb, wr_addr[ADDR_W-1:0]}] <= wr_pixel;
      end
   end

   // Line storage registered read port.
   always_ff @(posedge clk24) begin
      ram_q <= mem[{rb, rd_addr[ADDR_W-1:0]}];
   end

   // Read-side sequencing: restart on rd_start, alternate first/repeat pass, flag writer lapping reader.
   always_ff @(posedge clk24) begin
      if (reset) begin
         rb        <= LAST_BANK;
         rd_addr   <= LEN;
         rd_repeat <= 1'b0;
         collide   <= 1'b0;
      end else begin
         collide <= rd_start && (rb_next == wb_next);
         if (rd_start) begin
            rd_addr   <= '0;
            rd_repeat <= ~rd_repeat;
            rb        <= rb_next;
         end else if (rd_addr < LEN) begin
            rd_addr <= rd_addr + 1'b1;
         end
      end
   end

   // Output pipeline: visibility and dim select delayed to line up with the RAM read register.
   always_ff @(posedge clk24) begin
      if (reset) begin
         act_d1    <= 1'b0;
         dim_d1    <= 1'b0;
         out_pixel <= '0;
      end else begin
         act_d1 <= rd_active && (rd_addr < LEN);
         dim_d1 <= scanline_en && rd_repeat;
         if (!act_d1) begin
            out_pixel <= '0;
         end else if (dim_d1) begin
            out_pixel <= (ram_q >> 1) & DIM_MASK;
         end else begin
            out_pixel <= ram_q;
         end
      end
   end

endmodule

// File: tb/tb_scan_doubler_n.sv
// tb_scan_doubler_n: directed and random stimulus against a behavioural line-buffer model.
module tb_scan_doubler_n;

   localparam int PW  = 8;
   localparam int CHW = 4;
   localparam int LEN = 512;
   localparam int AW  = 9;
   localparam int NL  = 2;

   logic          clk24 = 1'b0;
   logic          reset;
   logic          ce_wr;
   logic [PW-1:0] wr_pixel;
   logic          wr_start;
   logic          rd_start;
   logic          rd_active;
   logic          scanline_en;
   logic [PW-1:0] out_pixel;
   logic          rd_repeat;
   logic          wr_ovf;
   logic          collide;

   int total = 0;
   int bad   = 0;
   int collide_count = 0;
   string phase = "init";

   // Reference model state
   logic [PW-1:0] ref_mem   [NL][LEN];
   bit            ref_known [NL][LEN];
   int            m_wb, m_last, m_rb, m_wptr, m_rptr;
   bit            m_rep, m_ovf, m_col;
   bit            p_act, p_known, p_dim;
   logic [PW-1:0] p_val;
   logic [PW-1:0] exp_out = '0;
   bit            exp_known = 1'b1;

   always #5 clk24 = ~clk24;

   scan_doubler_n #(
      .PIXEL_W (PW),
      .CH_W    (CHW),
      .LINE_LEN(LEN),
      .ADDR_W  (AW),
      .NLINES  (NL)
   ) dut (
      .clk24      (clk24),
      .reset      (reset),
      .ce_wr      (ce_wr),
      .wr_pixel   (wr_pixel),
      .wr_start   (wr_start),
      .rd_start   (rd_start),
      .rd_active  (rd_active),
      .scanline_en(scanline_en),
      .out_pixel  (out_pixel),
      .rd_repeat  (rd_repeat),
      .wr_ovf     (wr_ovf),
      .collide    (collide)
   );

   // Halve every CHW-bit channel independently
   function automatic logic [PW-1:0] dimmed(input logic [PW-1:0] v);
      int base  = 1 << CHW;
      int scale = 1;
      int val   = int'(v);
      int res   = 0;
      for (int c = 0; c < (PW + CHW - 1) / CHW; c++) begin
         res   = res + (((val / scale) % base) / 2) * scale;
         scale = scale * base;
      end
      return PW'(res);
   endfunction

   function automatic logic [PW-1:0] linePixel(input int mode, input int i);
      case (mode)
         0:       return PW'(i);
         1:       return 8'hFF;
         2:       return PW'(i) ^ 8'hA5;
         default: return PW'(i + 8'h3C);
      endcase
   endfunction

   // Advance the model by one clock edge using the inputs presented before it
   task automatic modelEdge();
      int old_wb;
      int old_last;
      if (reset) begin
         m_wb = 0; m_last = NL - 1; m_rb = NL - 1; m_wptr = 0; m_rptr = LEN;
         m_rep = 0; m_ovf = 0; m_col = 0;
         p_act = 0; p_known = 0; p_dim = 0; p_val = '0;
         exp_out = '0; exp_known = 1;
      end else begin
         if (!p_act) begin
            exp_out = '0; exp_known = 1;
         end else if (!p_known) begin
            exp_known = 0;
         end else begin
            exp_out = p_dim ? dimmed(p_val) : p_val;
            exp_known = 1;
         end
         p_act   = rd_active && (m_rptr < LEN);
         p_dim   = scanline_en && m_rep;
         p_known = 0;
         p_val   = '0;
         if (p_act) begin
            p_val   = ref_mem[m_rb][m_rptr];
            p_known = ref_known[m_rb][m_rptr];
         end
         old_wb   = m_wb;
         old_last = m_last;
         if (wr_start) begin
            m_last = old_wb; m_wb = (old_wb + 1) % NL; m_wptr = 0; m_ovf = 0;
         end else if (ce_wr) begin
            if (m_wptr < LEN) begin
               ref_mem[old_wb][m_wptr]   = wr_pixel;
               ref_known[old_wb][m_wptr] = 1;
               m_wptr++;
            end else begin
               m_ovf = 1;
            end
         end
         if (rd_start) begin
            m_rptr = 0;
            if (m_rep) m_rb = wr_start ? old_wb : old_last;
            m_rep = !m_rep;
            m_col = (m_rb == m_wb);
         end else begin
            m_col = 0;
            if (m_rptr < LEN) m_rptr++;
         end
      end
   endtask

   task automatic checkValue(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      if (collide === 1'b1) collide_count++;
      checkValue("rd_repeat", {7'd0, rd_repeat}, {7'd0, m_rep});
      checkValue("wr_ovf", {7'd0, wr_ovf}, {7'd0, m_ovf});
      checkValue("collide", {7'd0, collide}, {7'd0, m_col});
      if (exp_known) checkValue("out_pixel", out_pixel, exp_out);
   endtask

   task automatic applyStimulus(input bit rst, input bit ce, input logic [PW-1:0] pix,
                                input bit ws, input bit rs, input bit act, input bit scan);
      reset = rst; ce_wr = ce; wr_pixel = pix; wr_start = ws;
      rd_start = rs; rd_active = act; scanline_en = scan;
      @(posedge clk24);
      modelEdge();
      #1;
      checkOutput();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0, 0, 1, 0);
   endtask

   task automatic writeLine(input int n, input int gap, input int mode);
      for (int i = 0; i < n; i++) begin
         for (int g = 1; g < gap; g++) applyStimulus(0, 0, '0, 0, 0, 0, 0);
         applyStimulus(0, 1, linePixel(mode, i), 0, 0, 0, 0);
      end
   endtask

   // Start an output line and play it out; spot-check one pixel against a known constant
   task automatic readLine(input bit scan, input int spot_idx, input logic [PW-1:0] spot_val, input bit same_ws);
      applyStimulus(0, 0, '0, same_ws, 1, 1, scan);
      for (int c = 1; c <= LEN + 2; c++) begin
         applyStimulus(0, 0, '0, 0, 0, 1, scan);
         if (c - 2 == spot_idx) checkValue("spot", out_pixel, spot_val);
      end
   endtask

   initial begin
      for (int b = 0; b < NL; b++)
         for (int a = 0; a < LEN; a++) begin
            ref_known[b][a] = 0;
            ref_mem[b][a]   = '0;
         end
      reset = 1; ce_wr = 0; wr_pixel = '0; wr_start = 0; rd_start = 0; rd_active = 0; scanline_en = 0;

      phase = "reset";
      $display("[TB] phase %s", phase);
      applyStimulus(1, 0, '0, 0, 0, 0, 0);
      applyStimulus(1, 0, '0, 0, 0, 0, 0);
      for (int i = 0; i < 100; i++) begin
         applyStimulus(0, 0, '0, 0, 0, 0, 0);
         checkValue("idle_out", out_pixel, 8'h00);
         checkValue("idle_ovf", {7'd0, wr_ovf}, 8'h00);
         checkValue("idle_collide", {7'd0, collide}, 8'h00);
      end

      phase = "double";
      $display("[TB] phase %s", phase);
      applyStimulus(0, 0, '0, 0, 1, 0, 0);
      writeLine(LEN, 2, 0);
      applyStimulus(0, 0, '0, 1, 0, 0, 0);
      readLine(0, 1, 8'd1, 0);
      checkValue("first_pass", {7'd0, rd_repeat}, 8'd0);
      readLine(0, 300, 8'd44, 0);
      checkValue("repeat_pass", {7'd0, rd_repeat}, 8'd1);

      phase = "dim";
      $display("[TB] phase %s", phase);
      writeLine(16, 1, 1);
      applyStimulus(0, 0, '0, 1, 0, 0, 0);
      readLine(1, 5, 8'hFF, 0);
      readLine(1, 5, 8'h77, 0);

      phase = "overflow";
      $display("[TB] phase %s", phase);
      for (int i = 0; i < 520; i++) begin
         applyStimulus(0, 1, linePixel(2, i), 0, 0, 0, 0);
         if (i == 511) checkValue("ovf_before", {7'd0, wr_ovf}, 8'd0);
         if (i == 512) checkValue("ovf_after", {7'd0, wr_ovf}, 8'd1);
      end
      applyStimulus(0, 0, '0, 1, 0, 0, 0);
      checkValue("ovf_clear", {7'd0, wr_ovf}, 8'd0);
      readLine(0, 511, 8'h5A, 0);
      readLine(0, 511, 8'h5A, 0);

      phase = "bypass";
      $display("[TB] phase %s", phase);
      writeLine(32, 1, 3);
      readLine(0, 4, 8'h40, 1);

      phase = "collide";
      $display("[TB] phase %s", phase);
      collide_count = 0;
      applyStimulus(0, 0, '0, 0, 1, 1, 0); idle(8);
      applyStimulus(0, 0, '0, 0, 1, 1, 0); idle(8);
      applyStimulus(0, 0, '0, 1, 0, 1, 0); idle(8);
      applyStimulus(0, 0, '0, 0, 1, 1, 0); idle(8);
      applyStimulus(0, 0, '0, 1, 0, 1, 0); idle(8);
      applyStimulus(0, 0, '0, 0, 1, 1, 0); idle(8);
      checkValue("collide_count", PW'(collide_count), 8'd1);

      phase = "midreset";
      $display("[TB] phase %s", phase);
      applyStimulus(0, 0, '0, 0, 1, 1, 0);
      idle(20);
      applyStimulus(1, 0, '0, 0, 0, 1, 0);
      checkValue("reset_out", out_pixel, 8'h00);
      idle(10);

      phase = "random";
      $display("[TB] phase %s", phase);
      for (int i = 0; i < 4000; i++) begin
         applyStimulus(($urandom % 600) == 0, $urandom % 2, PW'($urandom),
                       ($urandom % 50) == 0, ($urandom % 40) == 0,
                       ($urandom % 8) != 0, $urandom % 2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
